// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding the BPU/decode stage.
//
// Generates sequential word-aligned fetch addresses and issues them on a
// request/grant instruction bus. In-order responses are paired with their
// request address through a side address FIFO, then buffered in a small
// fetch queue that presents one instruction per cycle. An execute flush or
// a BPU taken prediction redirects the PC. Responses still in flight at
// that moment are counted in `drop` and discarded when they return.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   FQ_DEPTH  fetch queue entries == max outstanding requests (pow2, 2..8)
//
// Ports:
//   i_clk, i_rstn              clock, async active-low reset
//   i_stop                     downstream stall, head is not consumed
//   i_flush, i_flush_addr      execute redirect (wins over BPU)
//   i_bpu_taken, i_bpu_jaddr   BPU taken on the presented instruction
//   o_ibus_req, o_ibus_addr    fetch request / word address
//   i_ibus_gnt                 request accepted this cycle
//   i_ibus_rvld, i_ibus_rdata  in-order response, one per grant
//   o_data_vld, o_iaddr, o_data  presented instruction
//
// Build option:
//   IFU_RSP_BYPASS_EN  when defined, a response arriving at an empty queue
//                      (no pending drop, no flush) is presented in the same
//                      cycle. When undefined, every response goes through
//                      the queue, giving one cycle of latency and no
//                      combinational path from rdata to o_data.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_stop,
  input  logic        i_flush,
  input  logic [31:0] i_flush_addr,
  input  logic        i_bpu_taken,
  input  logic [31:0] i_bpu_jaddr,
  output logic        o_ibus_req,
  output logic [31:0] o_ibus_addr,
  input  logic        i_ibus_gnt,
  input  logic        i_ibus_rvld,
  input  logic [31:0] i_ibus_rdata,
  output logic        o_data_vld,
  output logic [31:0] o_iaddr,
  output logic [31:0] o_data
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fq_ent_t;

  logic [31:0]   pc;
  logic          run;        // holds off the first request until the first edge after reset
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [PW-1:0] q_rd, q_wr;
  logic [PW-1:0] a_rd, a_wr;
  fq_ent_t       fq    [FQ_DEPTH];
  logic [31:0]   afifo [FQ_DEPTH];

  logic [CW:0]   inflight;
  logic          q_nonempty, drop_any;
  logic          fire, redirect, grant, rsp_keep, q_push, q_pop;
  logic [31:0]   tgt_raw, target;

  assign q_nonempty = (count != '0);
  assign drop_any   = (drop != '0);
  assign inflight   = {1'b0, outst} + {1'b0, count};

  // A response only pairs with the address FIFO head when it is not a drop.
  assign rsp_keep   = i_ibus_rvld & ~drop_any;

`ifdef IFU_RSP_BYPASS_EN
  logic byp;
  // Bypass excludes only i_flush: a taken redirect can only come from the
  // presented instruction itself, so including it would form a loop.
  assign byp        = ~q_nonempty & ~drop_any & i_ibus_rvld & ~i_flush;
  assign o_data_vld = q_nonempty | byp;
  assign o_iaddr    = byp ? afifo[a_rd]  : fq[q_rd].addr;
  assign o_data     = byp ? i_ibus_rdata : fq[q_rd].data;
  assign q_push     = rsp_keep & ~redirect & ~(byp & ~i_stop);
`else
  assign o_data_vld = q_nonempty;
  assign o_iaddr    = fq[q_rd].addr;
  assign o_data     = fq[q_rd].data;
  assign q_push     = rsp_keep & ~redirect;
`endif

  assign fire     = o_data_vld & ~i_stop;
  assign q_pop    = fire & q_nonempty;
  assign redirect = i_flush | (i_bpu_taken & fire);
  assign tgt_raw  = i_flush ? i_flush_addr : i_bpu_jaddr;
  assign target   = tgt_raw & 32'hFFFF_FFFC;

  // outst + count bounds both queue space and address FIFO occupancy.
  assign o_ibus_req  = run & ~redirect & (inflight < (CW+1)'(FQ_DEPTH));
  assign o_ibus_addr = pc;
  assign grant       = o_ibus_req & i_ibus_gnt;

  // PC, outstanding and drop accounting
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      run   <= 1'b0;
      pc    <= RESET_PC;
      outst <= '0;
      drop  <= '0;
    end else begin
      run   <= 1'b1;
      outst <= outst + CW'(grant) - CW'(i_ibus_rvld);
      if (redirect) begin
        pc   <= target;
        // Everything still outstanding after this cycle's response is
        // stale; pending drops are already part of outst.
        drop <= outst - CW'(i_ibus_rvld);
      end else begin
        if (grant)
          pc <= pc + 32'd4;
        drop <= drop - CW'(i_ibus_rvld & drop_any);
      end
    end
  end

  // Address FIFO: one entry per granted, non-dropped request
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      a_rd <= '0;
      a_wr <= '0;
      for (int i = 0; i < FQ_DEPTH; i++)
        afifo[i] <= '0;
    end else if (redirect) begin
      a_rd <= '0;
      a_wr <= '0;
    end else begin
      if (grant) begin
        afifo[a_wr] <= pc;
        a_wr        <= a_wr + PW'(1);
      end
      if (rsp_keep)
        a_rd <= a_rd + PW'(1);
    end
  end

  // Fetch queue
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      q_rd  <= '0;
      q_wr  <= '0;
      count <= '0;
      for (int i = 0; i < FQ_DEPTH; i++)
        fq[i] <= '0;
    end else if (redirect) begin
      q_rd  <= '0;
      q_wr  <= '0;
      count <= '0;
    end else begin
      if (q_push) begin
        fq[q_wr] <= '{addr: afifo[a_rd], data: i_ibus_rdata};
        q_wr     <= q_wr + PW'(1);
      end
      if (q_pop)
        q_rd <= q_rd + PW'(1);
      case ({q_push, q_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch (default build, RESET_PC=0x100, FQ_DEPTH=4).
// A small in-order bus model returns imem(addr) for every grant after a
// configurable delay; a cycle table covers the steady stream, stall, BPU
// taken and flush. Hand sequences cover flush with a same-cycle response,
// back-to-back flushes, PC wrap under random grant/delay, and async reset.
module tb_ifu_fetch;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b1;
  logic        i_stop = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_flush_addr = '0;
  logic        i_bpu_taken = 1'b0;
  logic [31:0] i_bpu_jaddr = '0;
  logic        o_ibus_req;
  logic [31:0] o_ibus_addr;
  logic        i_ibus_gnt = 1'b0;
  logic        i_ibus_rvld = 1'b0;
  logic [31:0] i_ibus_rdata = '0;
  logic        o_data_vld;
  logic [31:0] o_iaddr;
  logic [31:0] o_data;

  always #5 i_clk = ~i_clk;

  ifu_fetch #(.RESET_PC(32'h0000_0100), .FQ_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_stop(i_stop),
    .i_flush(i_flush), .i_flush_addr(i_flush_addr),
    .i_bpu_taken(i_bpu_taken), .i_bpu_jaddr(i_bpu_jaddr),
    .o_ibus_req(o_ibus_req), .o_ibus_addr(o_ibus_addr), .i_ibus_gnt(i_ibus_gnt),
    .i_ibus_rvld(i_ibus_rvld), .i_ibus_rdata(i_ibus_rdata),
    .o_data_vld(o_data_vld), .o_iaddr(o_iaddr), .o_data(o_data)
  );

  typedef struct {
    bit          stop, flush;
    logic [31:0] faddr;
    bit          taken;
    logic [31:0] jaddr;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] iaddr;
  } vec_t;

  vec_t        tbl [26];
  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0] pq_addr [$];
  int          pq_rdy  [$];
  int          last_rdy = -1;
  int          dly_min = 1, dly_max = 1;
  bit          gnt_rand = 0, gnt_off = 0;
  logic        s_req, s_vld;
  logic [31:0] s_addr, s_iaddr, s_data;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(bit st, bit fl, logic [31:0] fa, bit tk, logic [31:0] ja,
                              bit rq, logic [31:0] ad, bit vl, logic [31:0] ia);
    vec_t v;
    v.stop = st; v.flush = fl; v.faddr = fa; v.taken = tk; v.jaddr = ja;
    v.req = rq; v.addr = ad; v.vld = vl; v.iaddr = ia;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm, input int got, input int want);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out with %0d of %0d instructions", nm, got, want);
  endtask

  // Called just after a negedge: drive bus inputs, settle, sample outputs.
  task automatic drive_bus();
    if (pq_addr.size() > 0 && pq_rdy[0] <= cyc) begin
      i_ibus_rvld  = 1'b1;
      i_ibus_rdata = imem(pq_addr[0]);
    end else begin
      i_ibus_rvld  = 1'b0;
      i_ibus_rdata = $urandom;
    end
    i_ibus_gnt = gnt_off ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    #1;
    s_req   = o_ibus_req;
    s_addr  = o_ibus_addr;
    s_vld   = o_data_vld;
    s_iaddr = o_iaddr;
    s_data  = o_data;
  endtask

  // Book this cycle's bus handshakes, then move to the next negedge.
  task automatic clk_adv();
    if (s_req && i_ibus_gnt) begin
      int r;
      r = cyc + int'($urandom_range(dly_min, dly_max));
      if (r <= last_rdy) r = last_rdy + 1;
      pq_addr.push_back(s_addr);
      pq_rdy.push_back(r);
      last_rdy = r;
    end
    if (i_ibus_rvld) begin
      void'(pq_addr.pop_front());
      void'(pq_rdy.pop_front());
    end
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
  endtask

  initial begin
    int k;
    logic [31:0] exp_g, exp_f;

    //         stop fl faddr        tk jaddr        req addr          vld iaddr
    tbl[0]  = mk(0, 0, 0,            0, 0,           1, 32'h100,       0, 0);
    tbl[1]  = mk(0, 0, 0,            0, 0,           1, 32'h104,       0, 0);
    tbl[2]  = mk(0, 0, 0,            0, 0,           1, 32'h108,       1, 32'h100);
    tbl[3]  = mk(0, 0, 0,            0, 0,           1, 32'h10C,       1, 32'h104);
    tbl[4]  = mk(0, 0, 0,            1, 32'h200,     0, 0,             1, 32'h108);
    tbl[5]  = mk(0, 0, 0,            0, 0,           1, 32'h200,       0, 0);
    tbl[6]  = mk(0, 0, 0,            0, 0,           1, 32'h204,       0, 0);
    tbl[7]  = mk(0, 0, 0,            0, 0,           1, 32'h208,       1, 32'h200);
    tbl[8]  = mk(1, 0, 0,            0, 0,           1, 32'h20C,       1, 32'h204);
    tbl[9]  = mk(1, 0, 0,            0, 0,           1, 32'h210,       1, 32'h204);
    tbl[10] = mk(1, 0, 0,            0, 0,           0, 0,             1, 32'h204);
    tbl[11] = mk(1, 0, 0,            0, 0,           0, 0,             1, 32'h204);
    tbl[12] = mk(1, 0, 0,            0, 0,           0, 0,             1, 32'h204);
    tbl[13] = mk(1, 0, 0,            0, 0,           0, 0,             1, 32'h204);
    tbl[14] = mk(0, 0, 0,            0, 0,           0, 0,             1, 32'h204);
    tbl[15] = mk(0, 0, 0,            0, 0,           1, 32'h214,       1, 32'h208);
    tbl[16] = mk(0, 0, 0,            0, 0,           1, 32'h218,       1, 32'h20C);
    tbl[17] = mk(0, 0, 0,            0, 0,           1, 32'h21C,       1, 32'h210);
    tbl[18] = mk(0, 0, 0,            0, 0,           1, 32'h220,       1, 32'h214);
    tbl[19] = mk(0, 1, 32'h403,      1, 32'h300,     0, 0,             1, 32'h218);
    tbl[20] = mk(0, 0, 0,            0, 0,           1, 32'h400,       0, 0);
    tbl[21] = mk(0, 0, 0,            0, 0,           1, 32'h404,       0, 0);
    tbl[22] = mk(0, 0, 0,            0, 0,           1, 32'h408,       1, 32'h400);
    tbl[23] = mk(1, 0, 0,            1, 32'h500,     1, 32'h40C,       1, 32'h404);
    tbl[24] = mk(0, 0, 0,            0, 0,           1, 32'h410,       1, 32'h404);
    tbl[25] = mk(0, 0, 0,            0, 0,           1, 32'h414,       1, 32'h408);

    // ---- reset values, then release ----
    #2 i_rstn = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    chk("reset req",   32'(o_ibus_req), 0);
    chk("reset vld",   32'(o_data_vld), 0);
    chk("reset iaddr", o_iaddr, 0);
    chk("reset data",  o_data, 0);
    i_rstn = 1'b1;
    #1;
    chk("req before first edge", 32'(o_ibus_req), 0);
    @(posedge i_clk);
    @(negedge i_clk);
    cyc = 0;

    // ---- cycle table: stream, taken, stall, flush+taken, taken under stop ----
    for (int i = 0; i < 26; i++) begin
      i_stop       = tbl[i].stop;
      i_flush      = tbl[i].flush;
      i_flush_addr = tbl[i].faddr;
      i_bpu_taken  = tbl[i].taken;
      i_bpu_jaddr  = tbl[i].jaddr;
      drive_bus();
      chk($sformatf("row%0d req", i), 32'(s_req), 32'(tbl[i].req));
      if (tbl[i].req)
        chk($sformatf("row%0d addr", i), s_addr, tbl[i].addr);
      chk($sformatf("row%0d vld", i), 32'(s_vld), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("row%0d iaddr", i), s_iaddr, tbl[i].iaddr);
        chk($sformatf("row%0d data", i), s_data, imem(tbl[i].iaddr));
      end
      clk_adv();
    end
    i_stop = 0; i_flush = 0; i_bpu_taken = 0;

    // ---- flush with 3 outstanding and a response in the same cycle ----
    gnt_off = 1;
    repeat (10) begin drive_bus(); clk_adv(); end
    drive_bus();
    chk("drained vld", 32'(s_vld), 0);
    clk_adv();
    gnt_off = 0;
    dly_min = 3; dly_max = 3;
    for (int j = 0; j < 3; j++) begin
      drive_bus();
      chk("seqA req", 32'(s_req), 1);
      chk("seqA addr", s_addr, 32'h418 + 32'(4 * j));
      clk_adv();
    end
    i_flush = 1; i_flush_addr = 32'h400;
    drive_bus();
    chk("seqA flush req", 32'(s_req), 0);
    clk_adv();
    i_flush = 0;
    dly_min = 1; dly_max = 1;
    drive_bus();
    chk("seqA post vld", 32'(s_vld), 0);
    chk("seqA post req", 32'(s_req), 1);
    chk("seqA post addr", s_addr, 32'h400);
    clk_adv();
    k = 0;
    for (int t = 0; t < 30 && k < 4; t++) begin
      drive_bus();
      if (s_vld) begin
        chk("seqA iaddr", s_iaddr, 32'h400 + 32'(4 * k));
        chk("seqA data", s_data, imem(32'h400 + 32'(4 * k)));
        k++;
      end
      clk_adv();
    end
    if (k < 4) timeout("seqA", k, 4);

    // ---- back-to-back flushes, then wrap with random grant/delay/stall ----
    dly_min = 3; dly_max = 3;
    repeat (4) begin drive_bus(); clk_adv(); end
    i_flush = 1; i_flush_addr = 32'h600;
    drive_bus();
    chk("seqB flush1 req", 32'(s_req), 0);
    clk_adv();
    i_flush_addr = 32'hFFFF_FFF3;
    drive_bus();
    chk("seqB flush2 req", 32'(s_req), 0);
    chk("seqB flush2 vld", 32'(s_vld), 0);
    clk_adv();
    i_flush = 0;
    gnt_rand = 1; dly_min = 1; dly_max = 3;
    exp_g = 32'hFFFF_FFF0;
    exp_f = 32'hFFFF_FFF0;
    k = 0;
    for (int t = 0; t < 400 && k < 12; t++) begin
      i_stop = ($urandom_range(0, 3) == 0);
      drive_bus();
      if (s_req && i_ibus_gnt) begin
        chk("seqB grant addr", s_addr, exp_g);
        exp_g = exp_g + 32'd4;
      end
      if (s_vld && !i_stop) begin
        chk("seqB iaddr", s_iaddr, exp_f);
        chk("seqB data", s_data, imem(exp_f));
        exp_f = exp_f + 32'd4;
        k++;
      end
      clk_adv();
    end
    if (k < 12) timeout("seqB", k, 12);
    i_stop = 0;
    gnt_rand = 0; dly_min = 1; dly_max = 1;

    // ---- asynchronous reset mid-stream ----
    #2 i_rstn = 1'b0;
    i_ibus_rvld = 1'b0;
    #1;
    chk("async reset req",   32'(o_ibus_req), 0);
    chk("async reset vld",   32'(o_data_vld), 0);
    chk("async reset iaddr", o_iaddr, 0);
    chk("async reset data",  o_data, 0);
    pq_addr.delete();
    pq_rdy.delete();
    last_rdy = cyc;
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
    for (int j = 0; j < 3; j++) begin
      drive_bus();
      chk("rst2 req", 32'(s_req), 1);
      chk("rst2 addr", s_addr, 32'h100 + 32'(4 * j));
      chk("rst2 vld", 32'(s_vld), (j == 2) ? 32'd1 : 32'd0);
      if (j == 2) begin
        chk("rst2 iaddr", s_iaddr, 32'h100);
        chk("rst2 data", s_data, imem(32'h100));
      end
      clk_adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
